ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receive deframer. It samples the serial ps2_data line once per kbd_clk rising edge, assembles 11-bit frames, checks parity and stop bit, and queues good scan-code bytes in a small FIFO. The LC-3 keyboard status/data register logic reads the FIFO through a valid/read-pulse interface. It is the receiving end of the keyboard serial stream.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
kbd_clk  input  1  clock; one serial bit per rising edge.
rst_n  input  1  synchronous active-low reset.
ps2_data  input  1  serial line; idle high.
rd_en  input  1  pop head byte; KBDR read strobe.
err_clr  input  1  clears all sticky error flags.
data_out  output  8  head-of-FIFO byte; valid only while data_valid=1.
data_valid  output  1  FIFO non-empty; drives KBSR ready bit.
parity_err  output  1  sticky; parity mismatch seen.
frame_err  output  1  sticky; stop bit sampled 0.
overflow  output  1  sticky; good byte dropped because FIFO was full.
busy  output  1  FSM is mid-frame (DATA, PARITY or STOP).

Behaviour:
- Reset (rst_n=0 at posedge kbd_clk): FIFO emptied, pointers and count=0, all error flags 0, data_valid=0, data_out=8'h00, busy=0, FSM goes to WAIT_IDLE. A partial frame in progress is discarded.
- Frame format: start bit 0, then data[7:0] LSB first, then odd parity bit (ones in data plus parity is odd), then stop bit 1. One bit per kbd_clk posedge, 11 cycles total.
- FSM states:
  - WAIT_IDLE: on ps2_data=1, go to IDLE.
  - IDLE: on ps2_data=0 (start bit), go to DATA with bit_cnt=0.
  - DATA: shift right, ps2_data enters bit 7. bit_cnt increments. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP:
    - ps2_data=1 and parity good: push the byte, go to IDLE.
    - ps2_data=1 and parity bad: set parity_err, drop the byte, go to IDLE.
    - ps2_data=0: set frame_err, drop the byte, go to WAIT_IDLE. Parity is not evaluated in this case.
- Back-to-back frames: the start bit is accepted in IDLE on the cycle immediately after the STOP cycle. No idle gap is required.
- Latency: the push happens at the STOP-cycle edge. data_valid=1 and data_out=byte are visible on the following cycle.
- FIFO:
  - data_out is driven combinationally from the head entry.
  - rd_en with data_valid=1 pops at the clock edge. rd_en while empty is ignored and has no error.
  - Push while full (with no simultaneous pop): byte dropped, overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur and count stays at DEPTH.
  - Push and pop in the same cycle with count=1: both occur and count stays at 1.
  - Pointers wrap modulo DEPTH.
- Error flags: sticky until err_clr=1. If a set event and err_clr occur in the same cycle, the set wins (flag ends at 1).
- busy=1 in DATA, PARITY and STOP; otherwise 0.

Optional Feature:
Macro PS2_RX_BREAK_FILTER_EN.
- Defined: a good byte 8'hF0 sets internal break_pending and is not pushed. The next good byte is also not pushed and clears break_pending. A parity or frame error clears break_pending. Reset clears break_pending. Net effect: only make codes reach the FIFO.
- Undefined: every good byte, including 8'hF0, is pushed. No break_pending logic exists.

Test Plan:
1. Reset, line idle high, then frame for 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) -> data_valid=1 one cycle after stop, data_out=8'h1C, no errors; rd_en pulse -> data_valid=0.
2. Frame 0x5A sent with parity bit 0 (should be 1) -> parity_err=1, data_valid stays 0. Assert err_clr -> parity_err=0. A new good 0x5A frame is then received correctly.
3. Frame 0x1C with stop bit 0, line held low 3 cycles, then high, then good 0x29 frame -> frame_err=1, no spurious start taken while low, data_out=8'h29.
4. DEPTH=4: send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no reads -> overflow=1, then pops yield 0x01..0x04 and data_valid=0 after the 4th pop. A pop on the STOP cycle of a 5th frame while full -> both accepted, no overflow.
5. Reset asserted mid-frame after 4 data bits, line released high -> all outputs at reset values. The next good 0x1C is received cleanly.
6. With PS2_RX_BREAK_FILTER_EN: send 0x1C, 0xF0, 0x1C, 0x32 -> FIFO holds 0x1C, 0x32 only. Without the macro -> FIFO holds all four bytes in order.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receive deframer with a small scan-code FIFO.
//   Samples ps2_data on every kbd_clk rising edge and assembles 11-bit frames:
//   start(0), data[7:0] LSB first, odd parity, stop(1).
//   Good bytes are queued and read through a valid/read-pulse interface.
// Ports:
//   kbd_clk    - clock, one serial bit per rising edge
//   rst_n      - synchronous active-low reset
//   ps2_data   - serial line, idle high
//   rd_en      - pop head byte (KBDR read strobe)
//   err_clr    - clears all sticky error flags
//   data_out   - head-of-FIFO byte, 8'h00 while empty
//   data_valid - FIFO non-empty (KBSR ready)
//   parity_err - sticky parity mismatch
//   frame_err  - sticky stop-bit-low
//   overflow   - sticky good byte dropped on full FIFO
//   busy       - mid-frame (DATA, PARITY or STOP)
// Optional: define PS2_RX_BREAK_FILTER_EN to swallow break sequences (F0 xx).
module ps2_kbd_rx #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic       kbd_clk,
  input  logic       rst_n,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;

  logic good_byte, set_perr, set_ferr, push_req, pop, push_ok, full;

  // Frame FSM
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    good_byte = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    case (state_q)
      S_WAIT_IDLE: if (ps2_data) state_d = S_IDLE;
      S_IDLE: begin
        if (!ps2_data) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        shift_d   = {ps2_data, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: begin
        par_d   = ps2_data;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (ps2_data) begin
          state_d = S_IDLE;
          // odd parity: data plus parity bit carry an odd number of ones
          if (^{shift_q, par_q}) good_byte = 1'b1;
          else                   set_perr  = 1'b1;
        end else begin
          state_d  = S_WAIT_IDLE;
          set_ferr = 1'b1;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

`ifdef PS2_RX_BREAK_FILTER_EN
  logic break_pending_q, break_pending_d;

  // F0 marks a break; it and the byte after it never reach the FIFO
  always_comb begin
    break_pending_d = break_pending_q;
    push_req        = 1'b0;
    if (good_byte) begin
      if (break_pending_q)        break_pending_d = 1'b0;
      else if (shift_q == 8'hF0)  break_pending_d = 1'b1;
      else                        push_req        = 1'b1;
    end
    if (set_perr || set_ferr) break_pending_d = 1'b0;
  end

  always_ff @(posedge kbd_clk) begin
    if (!rst_n) break_pending_q <= 1'b0;
    else        break_pending_q <= break_pending_d;
  end
`else
  assign push_req = good_byte;
`endif

  // FIFO and sticky flags
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = rd_en && (count_q != '0);
    // a pop in the same cycle frees the slot the push needs
    push_ok  = push_req && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push_ok && pop) count_d = count_q - (PTR_W+1)'(1);

    parity_err_d = err_clr ? 1'b0 : parity_err_q;
    frame_err_d  = err_clr ? 1'b0 : frame_err_q;
    overflow_d   = err_clr ? 1'b0 : overflow_q;
    if (set_perr)                  parity_err_d = 1'b1;
    if (set_ferr)                  frame_err_d  = 1'b1;
    if (push_req && full && !pop)  overflow_d   = 1'b1;
  end

  always_ff @(posedge kbd_clk) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero
  always_ff @(posedge kbd_clk) begin
    mem_q <= mem_d;
  end

  assign data_valid = (count_q != '0);
  assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: self-checking bench for ps2_kbd_rx.
//   Frames are built bit by bit; a frame-level reference model (byte queue plus
//   sticky flags) predicts data_valid, data_out, error flags and busy every cycle.
module tb_ps2_kbd_rx;
  localparam int unsigned DEPTH = 4;
  localparam int EV_NONE = 0, EV_GOOD = 1, EV_PAR = 2, EV_FRM = 3;

  logic       kbd_clk, rst_n, ps2_data, rd_en, err_clr;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, overflow, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  bit m_perr, m_ferr, m_ovf, m_brk;

  ps2_kbd_rx #(.DEPTH(DEPTH)) dut (
    .kbd_clk   (kbd_clk),
    .rst_n     (rst_n),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial kbd_clk = 1'b0;
  always #5 kbd_clk = ~kbd_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Effect of one clock edge on the reference: optional read, optional clear,
  // and the outcome of a frame that ends on this edge.
  task automatic model_edge(input bit rd, input bit clr, input int ev, input logic [7:0] b);
    bit full_before = (exp_q.size() == DEPTH);
    bit popped      = rd && (exp_q.size() > 0);
    bit push        = 1'b0;
    if (clr) begin
      m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    end
    if (popped) void'(exp_q.pop_front());
    case (ev)
      EV_GOOD: begin
`ifdef PS2_RX_BREAK_FILTER_EN
        if (m_brk)            m_brk = 1'b0;
        else if (b == 8'hF0)  m_brk = 1'b1;
        else                  push  = 1'b1;
`else
        push = 1'b1;
`endif
      end
      EV_PAR: begin m_perr = 1'b1; m_brk = 1'b0; end
      EV_FRM: begin m_ferr = 1'b1; m_brk = 1'b0; end
      default: ;
    endcase
    if (push) begin
      if (full_before && !popped) m_ovf = 1'b1;
      else                        exp_q.push_back(b);
    end
  endtask

  task automatic compare_all(input bit exp_busy);
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check("data_valid", 32'(data_valid), 32'(exp_q.size() > 0));
    check("data_out",   32'(data_out),   32'(head));
    check("parity_err", 32'(parity_err), 32'(m_perr));
    check("frame_err",  32'(frame_err),  32'(m_ferr));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("busy",       32'(busy),       32'(exp_busy));
  endtask

  // Called at a negedge; drives inputs, applies the edge, checks at the next negedge.
  task automatic step(input bit din, input bit rd, input bit clr, input int ev,
                      input logic [7:0] b, input bit exp_busy);
    ps2_data = din;
    rd_en    = rd;
    err_clr  = clr;
    @(posedge kbd_clk);
    model_edge(rd, clr, ev, b);
    @(negedge kbd_clk);
    compare_all(exp_busy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    @(posedge kbd_clk);
    exp_q.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0; m_brk = 1'b0;
    @(negedge kbd_clk);
    compare_all(1'b0);
    rst_n = 1'b1;
  endtask

  // rd_mode: 0 no reads, 1 random reads/clears, 2 read only on the stop cycle
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int rd_mode, input int low_hold);
    logic [10:0] bits;
    bit par, rd, clr;
    int ev;
    par  = (~^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rd  = (rd_mode == 1) ? ($urandom_range(0, 3) == 0) : (rd_mode == 2 && i == 10);
      clr = (rd_mode == 1 && i == 10) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (i < 10)        ev = EV_NONE;
      else if (bad_stop) ev = EV_FRM;
      else if (bad_par)  ev = EV_PAR;
      else               ev = EV_GOOD;
      step(bits[i], rd, clr, ev, b, i < 10);
    end
    if (bad_stop) begin
      // line held low must not be mistaken for a new start bit
      for (int k = 0; k < low_hold; k++) step(1'b0, 1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
    end
  endtask

  task automatic gap(input int n, input bit rnd);
    for (int k = 0; k < n; k++)
      step(1'b1, rnd && ($urandom_range(0, 2) == 0), rnd && ($urandom_range(0, 9) == 0),
           EV_NONE, 8'h00, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] partial;
    rst_n = 1'b0; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    do_reset();
    do_reset();
    gap(1, 1'b0);

    // basic receive and pop
    send_frame(8'h1C, 1'b0, 1'b0, 0, 0);
    drain(1);

    // parity error, clear, then clean receive
    send_frame(8'h5A, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, EV_NONE, 8'h00, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
    drain(1);

    // framing error with line held low, then clean receive
    send_frame(8'h1C, 1'b0, 1'b1, 0, 3);
    send_frame(8'h29, 1'b0, 1'b0, 0, 0);
    drain(1);
    step(1'b1, 1'b0, 1'b1, EV_NONE, 8'h00, 1'b0);

    // overflow, then simultaneous push/pop while full
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, EV_NONE, 8'h00, 1'b0);
    send_frame(8'h06, 1'b0, 1'b0, 2, 0);
    drain(5);

    // push and pop together with a single entry
    send_frame(8'h11, 1'b0, 1'b0, 0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 2, 0);
    drain(2);

    // reset in the middle of a frame
    partial = 8'hA5;
    step(1'b0, 1'b0, 1'b0, EV_NONE, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(partial[i], 1'b0, 1'b0, EV_NONE, 8'h00, 1'b1);
    do_reset();
    gap(1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 0, 0);
    drain(1);

    // break sequence handling
    send_frame(8'h1C, 1'b0, 1'b0, 0, 0);
    send_frame(8'hF0, 1'b0, 1'b0, 0, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 0, 0);
    send_frame(8'h32, 1'b0, 1'b0, 0, 0);
    drain(5);

    // randomized traffic
    for (int f = 0; f < 80; f++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'hF0 : 8'($urandom);
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 1,
                 $urandom_range(0, 3));
      gap($urandom_range(0, 2), 1'b1);
    end
    drain(DEPTH + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
